adder_tree_pipe: RTL

//  - Parametrised, fully pipelined unsigned adder tree: sums NUM_IN operands of IN_W bits,
//    one pairwise-add register stage per tree level, with a valid bit carried down the pipe.
//  - Generalises the fixed 4x14-bit two-stage adder; sits in datapaths that reduce channel

---
 rtl/adder_tree_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: fully pipelined unsigned adder tree, one register stage per level, valid carried alongside.
// Define ADDER_TREE_ACC_EN to add an accumulator stage after the tree (latency STAGES+1).
module adder_tree_pipe #(
  parameter  int NUM_IN = 4,
  parameter  int IN_W   = 14,
  parameter  int ACC_W  = 24,
  localparam int STAGES = $clog2(NUM_IN),
  localparam int SUM_W  = IN_W + STAGES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   acc_clr,
  output logic                   out_valid,
  output logic [SUM_W-1:0]       out_sum,
  output logic [ACC_W-1:0]       acc_out,
  output logic                   acc_ovf
);

  logic [STAGES:1] v_q;
  logic [STAGES:1] v_d;
  logic [STAGES:0] v_all;
  logic [SUM_W-1:0] tree_sum;

  assign v_all = {v_q, in_valid};
  assign v_d   = v_all[STAGES-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // Level k holds NUM_IN>>k partial sums, each one bit wider than the level above it.
  for (genvar k = 0; k <= STAGES; k++) begin : g_stage
    localparam int W = IN_W + k;
    localparam int N = NUM_IN >> k;
    logic [W-1:0] node [N];

    if (k == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_op
        assign node[i] = in_data[i*IN_W +: IN_W];
      end
    end else begin : g_reg
      logic [W-1:0] node_d [N];
      logic [W-1:0] node_q [N];

      always_comb begin
        for (int j = 0; j < N; j++) begin
          node_d[j] = node_q[j];
          if (v_all[k-1]) begin
            node_d[j] = {1'b0, g_stage[k-1].node[2*j]} + {1'b0, g_stage[k-1].node[2*j+1]};
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < N; j++) begin
            node_q[j] <= '0;
          end
        end else begin
          node_q <= node_d;
        end
      end

      assign node = node_q;
    end
  end

  assign tree_sum = g_stage[STAGES].node[0];

`ifdef ADDER_TREE_ACC_EN
  localparam int ACCX_W = ACC_W + 1;

  logic [STAGES:1] clr_q;
  logic [STAGES:1] clr_d;
  logic [STAGES:0] clr_all;
  logic            tree_valid;
  logic            tree_clr;
  logic [ACCX_W-1:0] acc_sum;
  logic [ACC_W-1:0]  acc_d, acc_q;
  logic              ovf_d, ovf_q;
  logic [SUM_W-1:0]  sum_d, sum_q;
  logic              valid_d, valid_q;

  // acc_clr only matters for accepted samples, so bubbles carry a zero down the pipe.
  assign clr_all    = {clr_q, in_valid & acc_clr};
  assign clr_d      = clr_all[STAGES-1:0];
  assign tree_valid = v_q[STAGES];
  assign tree_clr   = clr_q[STAGES];

  always_comb begin
    acc_sum = {1'b0, acc_q} + ACCX_W'(tree_sum);
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    valid_d = tree_valid;
    if (tree_valid) begin
      sum_d = tree_sum;
      if (tree_clr) begin
        acc_d = ACC_W'(tree_sum);
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
        ovf_d = ovf_q | acc_sum[ACC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      clr_q   <= clr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign acc_out   = acc_q;
  assign acc_ovf   = ovf_q;
`else
  logic unused_acc_clr;

  assign unused_acc_clr = acc_clr;
  assign out_valid      = v_q[STAGES];
  assign out_sum        = tree_sum;
  assign acc_out        = '0;
  assign acc_ovf        = 1'b0;
`endif

endmodule
